noc_out_port_arbiter: RTL and testbench
=======================================

Name: noc_out_port_arbiter

Overview:
- Sits at one output port (N, E, S, W or Local) of a mesh router, on the receiving side of the per-input routing blocks.
- Collects the one-bit route request each input port's routing block raises for this output.
- Round-robin arbitrates between those requests and locks the output to the winner for a whole packet (head to tail).
- Forwards flits through a one-entry registered output stage with valid/ready flow control to the downstream link.

Parameters:
- N_IN, 5, number of requesting input ports (N, E, S, W, Local); legal range 1..8.
- FLIT_W, 32, flit width in bits.

Ports:
- clk  input  1  router clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_IN  req[i] = this output's route bit from input i's routing block (already qualified by that block's valid).
- flit_in  input  N_IN*FLIT_W  flit presented by input i in bits [i*FLIT_W +: FLIT_W].
- tail_in  input  N_IN  tail_in[i] marks input i's current flit as the last flit of its packet.
- grant  output  N_IN  one-hot or zero; grant[i] = input i's flit is consumed this cycle (input pops on grant).
- out_valid  output  1  output register holds a flit.
- out_flit  output  FLIT_W  registered flit to downstream.
- out_tail  output  1  registered tail marker.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- busy  output  1  1 while in LOCKED.

Behaviour:
- Reset (async, rst_n=0): state IDLE, owner=0, rr_ptr=0, out_valid=0, out_flit=0, out_tail=0. grant is 0 combinationally while in reset and in IDLE. busy=0.
- State IDLE:
  - If req != 0, winner = first index j with req[j]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping mod N_IN.
  - Next cycle: state LOCKED, owner=winner.
  - No grant is issued in the IDLE cycle; arbitration costs one cycle per packet.
- State LOCKED:
  - space = !out_valid || out_ready.
  - grant[owner] = req[owner] && space, combinational; all other grant bits 0.
  - On a grant: out_flit<=flit_in[owner], out_tail<=tail_in[owner], out_valid<=1.
  - If a granted flit has tail_in[owner]=1: next state IDLE and rr_ptr<=(owner+1) mod N_IN.
  - If owner's req drops mid-packet: stay LOCKED, no grant, other requesters ignored.
- Output stage:
  - If out_valid && out_ready and no grant that cycle: out_valid<=0. out_flit and out_tail hold their last value.
  - Simultaneous drain and grant in the same cycle: register reloads and out_valid stays 1. This gives 1 flit/cycle throughput.
  - out_ready=0 with out_valid=1: register holds and grant stays 0.
- Latency:
  - First flit appears on out_flit 2 cycles after req rises in IDLE (arbitration cycle plus register).
  - Each subsequent flit appears 1 cycle after its grant.
- Single-flit packet (head carries tail): granted once, returns to IDLE; the next packet can be granted on the cycle after that.
- Fairness: rr_ptr changes only on packet completion. A continuously requesting input waits at most N_IN-1 packets.
- Wrap: owner=N_IN-1 completing sets rr_ptr=0. N_IN=1 degenerates to lock/unlock with rr_ptr fixed at 0.
- Reset mid-packet: immediate return to IDLE with out_valid=0. The partial packet is dropped; no recovery is required.
- grant is never asserted for an index whose req is 0.
- tail_in on a non-owner input is ignored.

Test Plan:
- Reset, then req=5'b00100, 3-flit packet 0xA1, 0xA2, 0xA3 (tail on 0xA3), out_ready=1 -> grant[2] asserted on cycles 1..3 after req; out_flit shows 0xA1, 0xA2, 0xA3 on cycles 2..4; out_tail=1 only with 0xA3; rr_ptr=3.
- req=5'b10011 held, every packet a single flit, out_ready=1 -> grant order 0, 1, 4, 0, 1; each grant separated by one arbitration cycle.
- Input 1 mid-packet while input 3 requests -> input 3 not granted until input 1's tail is granted; input 1 req low for 2 cycles leaves LOCKED with grant=0.
- out_ready=0 for 3 cycles with out_valid=1 -> out_flit stable, grant=0. out_ready back to 1 with req held -> drain and reload in the same cycle, out_valid stays 1.
- Owner=4 completes a packet while req=5'b10001 -> rr_ptr wraps to 0; input 0 wins next.
- rst_n pulsed low mid-packet during a grant -> out_valid=0, grant=0, busy=0 asynchronously. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/noc_out_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_out_port_arbiter_if
//
// Bundles the request side (from the per-input routing blocks) and the
// downstream link side of one router output port.
//
// Signals:
//   req       [N_IN]         route request from each input port
//   flit_in   [N_IN*FLIT_W]  flit presented by input i in [i*FLIT_W +: FLIT_W]
//   tail_in   [N_IN]         input i's current flit is the last of its packet
//   grant     [N_IN]         one-hot or zero; input i's flit is consumed
//   out_valid                output register holds a flit
//   out_flit  [FLIT_W]       registered flit to downstream
//   out_tail                 registered tail marker
//   out_ready                downstream can accept
//
// Handshake: on the input side a flit moves when grant[i] is 1 (grant[i]
// implies req[i]); the input pops it on that same rising edge. On the
// output side a flit moves on every rising edge where out_valid && out_ready;
// out_valid, out_flit and out_tail do not change while out_valid is 1 and
// out_ready is 0.
//
// Modports: slave = arbiter view, master = driver/link view.
// ---------------------------------------------------------------------------
interface noc_out_port_arbiter_if #(
    parameter int N_IN   = 5,
    parameter int FLIT_W = 32
);
    logic [N_IN-1:0]        req;
    logic [N_IN*FLIT_W-1:0] flit_in;
    logic [N_IN-1:0]        tail_in;
    logic [N_IN-1:0]        grant;
    logic                   out_valid;
    logic [FLIT_W-1:0]      out_flit;
    logic                   out_tail;
    logic                   out_ready;

    modport slave (
        input  req,
        input  flit_in,
        input  tail_in,
        input  out_ready,
        output grant,
        output out_valid,
        output out_flit,
        output out_tail
    );

    modport master (
        output req,
        output flit_in,
        output tail_in,
        output out_ready,
        input  grant,
        input  out_valid,
        input  out_flit,
        input  out_tail
    );
endinterface

// File: rtl/noc_out_port_arbiter.sv
// ---------------------------------------------------------------------------
// noc_out_port_arbiter
//
// Output-port arbiter of a mesh router. Picks one requesting input port in
// round-robin order, locks the output to it from head to tail, and forwards
// its flits through a one-entry registered output stage.
//
// Ports:
//   clk         router clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         noc_out_port_arbiter_if.slave (req/flit_in/tail_in/grant on
//               the input side, out_valid/out_flit/out_tail/out_ready on the
//               downstream side)
//   busy        1 while locked to a packet owner
//   state_dbg   current FSM state (0 = IDLE, 1 = LOCKED)
//   owner_dbg   current packet owner index (zero-extended to 3 bits)
//   rr_ptr_dbg  round-robin start index for the next arbitration
// ---------------------------------------------------------------------------
module noc_out_port_arbiter #(
    parameter int N_IN   = 5,
    parameter int FLIT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    noc_out_port_arbiter_if.slave       bus,
    output logic                        busy,
    output logic                        state_dbg,
    output logic [2:0]                  owner_dbg,
    output logic [2:0]                  rr_ptr_dbg
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_IN);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;

    logic [IDX_W-1:0]  winner;
    logic              winner_found;
    logic [IDX_W:0]    scan_sum;
    logic [IDX_W-1:0]  scan_idx;

    logic              owner_req;
    logic              owner_tail;
    logic [FLIT_W-1:0] owner_flit;

    logic              space;
    logic              grant_any;
    logic [N_IN-1:0]   grant_vec;

    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic              out_tail_q;

    // ------------------------------------------------------------------
    // Round-robin winner: first requester at or after rr_ptr, wrapping.
    // The offset sum never exceeds 2*N_IN-2, so one conditional subtract
    // is enough to wrap it back into range.
    // ------------------------------------------------------------------
    always_comb begin
        winner       = rr_ptr;
        winner_found = 1'b0;
        scan_sum     = '0;
        scan_idx     = '0;
        for (int k = 0; k < N_IN; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (scan_sum >= N_WIDE) begin
                scan_sum = scan_sum - N_WIDE;
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!winner_found && bus.req[scan_idx]) begin
                winner_found = 1'b1;
                winner       = scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner's request, flit and tail selected from the flattened buses.
    // ------------------------------------------------------------------
    always_comb begin
        owner_req  = 1'b0;
        owner_tail = 1'b0;
        owner_flit = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_req  = bus.req[i];
                owner_tail = bus.tail_in[i];
                owner_flit = bus.flit_in[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // The output register can take a flit when empty or when its current
    // flit leaves this same cycle; this is what sustains 1 flit/cycle.
    assign space = !out_valid_q || bus.out_ready;

    // rst_n is folded in so grant drops the moment reset is asserted,
    // without waiting for the state register to be cleared.
    assign grant_any = rst_n && (state == LOCKED) && owner_req && space;

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < N_IN; i++) begin
            grant_vec[i] = grant_any && (owner == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, owner and round-robin pointer.
    // The pointer moves only when a packet's tail is granted.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (winner_found) begin
                    state_nxt = LOCKED;
                    owner_nxt = winner;
                end
            end
            LOCKED: begin
                if (grant_any && owner_tail) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // One-entry output stage. A grant always reloads (covering the
    // simultaneous drain + load case); otherwise a drain just clears
    // valid and leaves the data bits holding their last value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_tail_q  <= 1'b0;
        end else if (grant_any) begin
            out_valid_q <= 1'b1;
            out_flit_q  <= owner_flit;
            out_tail_q  <= owner_tail;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.grant     = grant_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flit  = out_flit_q;
    assign bus.out_tail  = out_tail_q;

    assign busy       = (state == LOCKED);
    assign state_dbg  = (state == LOCKED);
    assign owner_dbg  = 3'(owner);
    assign rr_ptr_dbg = 3'(rr_ptr);

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_out_port_arbiter
//
// Per-input packet sources feed the arbiter; a cycle-level reference model
// derived from the arbitration rules predicts grants, busy, rr_ptr and the
// output register, and pushes every granted flit into exp_q. A separate
// monitor pops exp_q on each downstream handshake.
// ---------------------------------------------------------------------------
module tb_noc_out_port_arbiter;

    localparam int N_IN   = 5;
    localparam int FLIT_W = 32;
    localparam int W      = FLIT_W + 1;   // {tail, flit}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    noc_out_port_arbiter_if #(.N_IN(N_IN), .FLIT_W(FLIT_W)) bus ();

    logic       busy;
    logic       state_dbg;
    logic [2:0] owner_dbg;
    logic [2:0] rr_ptr_dbg;

    noc_out_port_arbiter #(.N_IN(N_IN), .FLIT_W(FLIT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .state_dbg  (state_dbg),
        .owner_dbg  (owner_dbg),
        .rr_ptr_dbg (rr_ptr_dbg)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [W-1:0]    src_q [N_IN][$];
    logic [W-1:0]    exp_q [$];
    int              grant_log [$];
    int              grant_cyc [$];
    logic [N_IN-1:0] stall;
    logic [N_IN-1:0] g_seen;
    logic            rdy;

    // reference model state
    bit              m_locked;
    int              m_owner;
    int              m_rr;
    bit              m_ov;
    logic [W-1:0]    m_out;
    logic [N_IN-1:0] m_eg;
    bit              m_was_locked;
    bit              m_found;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + per-cycle checks ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            m_eg = '0;
            if (m_locked && bus.req[m_owner] && (!m_ov || bus.out_ready))
                m_eg[m_owner] = 1'b1;

            chk("grant", bus.grant, m_eg);
            chk("busy", busy, m_locked);
            chk("rr_ptr", rr_ptr_dbg, m_rr);
            chk("out_valid", bus.out_valid, m_ov);
            if (m_ov) chk("out_word", {bus.out_tail, bus.out_flit}, m_out);

            g_seen       = bus.grant;
            m_was_locked = m_locked;

            if (m_eg != '0) begin
                m_out = {bus.tail_in[m_owner], bus.flit_in[m_owner*FLIT_W +: FLIT_W]};
                exp_q.push_back(m_out);
                grant_log.push_back(m_owner);
                grant_cyc.push_back(cyc);
                m_ov = 1'b1;
                if (m_out[FLIT_W]) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % N_IN;
                end
            end else if (m_ov && bus.out_ready) begin
                m_ov = 1'b0;
            end

            if (!m_was_locked && bus.req != '0) begin
                m_found = 1'b0;
                for (int k = 0; k < N_IN; k++) begin
                    if (!m_found && bus.req[(m_rr + k) % N_IN]) begin
                        m_found  = 1'b1;
                        m_owner  = (m_rr + k) % N_IN;
                        m_locked = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got 0x%0h with nothing expected (cycle %0d)",
                         {bus.out_tail, bus.out_flit}, cyc);
            end else begin
                chk("out_order", {bus.out_tail, bus.out_flit}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive();
        for (int i = 0; i < N_IN; i++) begin
            if (src_q[i].size() > 0 && !stall[i]) begin
                bus.req[i]                       = 1'b1;
                bus.flit_in[i*FLIT_W +: FLIT_W]  = src_q[i][0][FLIT_W-1:0];
                bus.tail_in[i]                   = src_q[i][0][FLIT_W];
            end else begin
                bus.req[i]                       = 1'b0;
                bus.flit_in[i*FLIT_W +: FLIT_W]  = $urandom;
                bus.tail_in[i]                   = 1'($urandom_range(0, 1));
            end
        end
        bus.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_IN; i++)
            if (g_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        g_seen = '0;
        drive();
    endtask

    task automatic push_pkt(input int port, input int len, input logic [FLIT_W-1:0] base);
        for (int f = 0; f < len; f++)
            src_q[port].push_back({(f == len - 1) ? 1'b1 : 1'b0, base + FLIT_W'(f)});
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        rst_n = 1'b0;
        for (int i = 0; i < N_IN; i++) src_q[i].delete();
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", busy, 0);
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_ov     = 1'b0;
        exp_q.delete();
        g_seen = '0;
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    task automatic check_log(input string name, input int exp_ids[$]);
        if (grant_log.size() < exp_ids.size()) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d grants required %0d", name, grant_log.size(), exp_ids.size());
        end else begin
            for (int k = 0; k < exp_ids.size(); k++) chk(name, grant_log[k], exp_ids[k]);
        end
    endtask

    // ---------------- stimulus ----------------
    int r;
    int drained;

    initial begin
        rst_n    = 1'b0;
        rdy      = 1'b1;
        stall    = '0;
        g_seen   = '0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_rr     = 0;
        m_ov     = 1'b0;
        m_out    = '0;
        drive();
        #12;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_flit", bus.out_flit, 0);
        chk("reset_out_tail", bus.out_tail, 0);
        chk("reset_grant", bus.grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rr_ptr", rr_ptr_dbg, 0);
        chk("reset_state", state_dbg, 0);
        #1;
        rst_n = 1'b1;

        // T1: one 3-flit packet on input 2
        grant_log.delete(); grant_cyc.delete();
        push_pkt(2, 3, 32'hA1);
        step();
        r = cyc;
        repeat (7) step();
        check_log("t1_grant_owner", '{2, 2, 2});
        if (grant_cyc.size() >= 3) begin
            chk("t1_first_grant_latency", grant_cyc[0] - r, 1);
            chk("t1_grant_back_to_back", grant_cyc[2] - grant_cyc[0], 2);
        end
        chk("t1_rr_ptr", rr_ptr_dbg, 3);

        // T2: inputs 0, 1, 4 sending single-flit packets
        step();
        reset_pulse();
        grant_log.delete(); grant_cyc.delete();
        for (int k = 0; k < 2; k++) begin
            push_pkt(0, 1, 32'hB0 + k);
            push_pkt(1, 1, 32'hB8 + k);
            push_pkt(4, 1, 32'hBC + k);
        end
        repeat (16) step();
        check_log("t2_grant_order", '{0, 1, 4, 0, 1});
        if (grant_cyc.size() >= 5)
            for (int k = 1; k < 5; k++) chk("t2_grant_spacing", grant_cyc[k] - grant_cyc[k-1], 2);

        // T3: input 1 owns the port, drops req mid-packet while input 3 waits
        step();
        reset_pulse();
        grant_log.delete(); grant_cyc.delete();
        push_pkt(1, 4, 32'hC0);
        push_pkt(3, 1, 32'hD0);
        repeat (3) step();
        stall[1] = 1'b1;
        repeat (2) step();
        stall = '0;
        repeat (10) step();
        check_log("t3_lock_order", '{1, 1, 1, 1, 3});

        // T4: downstream back-pressure for 3 cycles
        step();
        reset_pulse();
        push_pkt(0, 6, 32'hE0);
        repeat (3) step();
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        repeat (10) step();

        // T5: owner 4 completes while inputs 4 and 0 both request
        step();
        reset_pulse();
        push_pkt(3, 1, 32'hF3);
        repeat (4) step();
        chk("t5_rr_before", rr_ptr_dbg, 4);
        grant_log.delete(); grant_cyc.delete();
        push_pkt(4, 2, 32'h40);
        push_pkt(0, 1, 32'h00);
        repeat (8) step();
        check_log("t5_wrap_order", '{4, 4, 0});
        chk("t5_rr_after", rr_ptr_dbg, 1);

        // T6: reset asserted while a grant is active
        step();
        reset_pulse();
        push_pkt(2, 8, 32'h60);
        repeat (4) step();
        chk("t6_grant_before_reset", bus.grant, 5'b00100);
        reset_pulse();
        grant_log.delete(); grant_cyc.delete();
        push_pkt(1, 1, 32'h71);
        push_pkt(3, 1, 32'h73);
        repeat (8) step();
        check_log("t6_restart_order", '{1, 3});

        // T7: random traffic, stalls and back-pressure
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, N_IN - 1);
                if (src_q[p].size() < 6) push_pkt(p, $urandom_range(1, 4), $urandom);
            end
            stall = N_IN'($urandom & $urandom & $urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            step();
        end

        // drain everything
        stall   = '0;
        rdy     = 1'b1;
        drained = 0;
        for (int n = 0; n < 400 && !drained; n++) begin
            step();
            drained = 1;
            for (int i = 0; i < N_IN; i++) if (src_q[i].size() != 0) drained = 0;
            if (exp_q.size() != 0 || m_ov) drained = 0;
        end
        total++;
        if (!drained) begin
            bad++;
            $display("FAIL drain: got traffic still pending required all sources and outputs empty");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
